// File: rtl/row_unit_sched_pkg.sv
// Shared types, width helper and parameter-check macro for the row-unit layer scheduler.
package row_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ITER_END,
        ST_DONE
    } state_t;

    // Bits needed to hold n distinct values (0..n-1), never less than one.
    function automatic int clog2_w(input int n);
        int w;
        for (w = 1; (1 << w) < n; w++) begin
        end
        return w;
    endfunction

endpackage

`ifndef ROW_SCHED_PARAM_CHECK
`define ROW_SCHED_PARAM_CHECK(cond_, label_) \
    if (!(cond_)) begin : label_ \
        $error("row_unit_sched: illegal parameter combination"); \
    end
`endif

// File: rtl/row_unit_sched_if.sv
// Control/strobe bundle between decoder control, the scheduler and the row-unit memories.
interface row_unit_sched_if #(
    parameter int LBITS = 4,
    parameter int IBITS = 4
);
    logic             start;
    logic             syn_ok;
    logic             rd_en;
    logic [LBITS-1:0] rd_addr;
    logic             emem_wr_en;
    logic [LBITS-1:0] emem_wr_addr;
    logic             llr_wr_en;
    logic [LBITS-1:0] llr_wr_addr;
    logic             busy;
    logic             done;
    logic             converged;
    logic [IBITS-1:0] iter_cnt;

    modport master (
        input  start, syn_ok,
        output rd_en, rd_addr, emem_wr_en, emem_wr_addr, llr_wr_en, llr_wr_addr,
        output busy, done, converged, iter_cnt
    );

    modport slave (
        output start, syn_ok,
        input  rd_en, rd_addr, emem_wr_en, emem_wr_addr, llr_wr_en, llr_wr_addr,
        input  busy, done, converged, iter_cnt
    );
endinterface

// File: rtl/row_unit_sched.sv
// Layer/iteration scheduler: issues one layer read per PIPE_LAT+1 cycles, times E and LLR/D write-backs.
// Latency: start to done = MAXITER*(NLAYERS*(PIPE_LAT+1)+1)+1 cycles; every output is a register.
// No backpressure: start is ignored unless idle; ROW_SCHED_EARLY_TERM_EN enables convergence exit.
module row_unit_sched
    import row_sched_pkg::*;
#(
    parameter int NLAYERS  = 12,
    parameter int LBITS    = 4,
    parameter int MAXITER  = 10,
    parameter int IBITS    = 4,
    parameter int EMSG_LAT = 3,
    parameter int PIPE_LAT = 10
) (
    input  logic              clk,
    input  logic              rst,
    row_unit_sched_if.master  bus
);

    localparam int TBITS = clog2_w(PIPE_LAT + 1);
    localparam logic [TBITS-1:0] T_EMSG = TBITS'(EMSG_LAT);
    localparam logic [TBITS-1:0] T_PIPE = TBITS'(PIPE_LAT);
    localparam logic [LBITS-1:0] L_LAST = LBITS'(NLAYERS - 1);
    localparam logic [IBITS-1:0] I_MAX  = IBITS'(MAXITER);

`ifdef ROW_SCHED_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    `ROW_SCHED_PARAM_CHECK(PIPE_LAT > EMSG_LAT, g_chk_lat_order)
    `ROW_SCHED_PARAM_CHECK(EMSG_LAT >= 1, g_chk_emsg_min)
    `ROW_SCHED_PARAM_CHECK((NLAYERS >= 1) && (NLAYERS <= (1 << LBITS)), g_chk_layers)
    `ROW_SCHED_PARAM_CHECK((MAXITER >= 1) && (MAXITER < (1 << IBITS)), g_chk_iters)

    state_t           r_state;
    logic [TBITS-1:0] r_timer;
    logic [LBITS-1:0] r_layer;
    logic [IBITS-1:0] r_iter;
    logic             r_all_ok;
    logic             r_conv;
    logic             r_rd_en;
    logic [LBITS-1:0] r_rd_addr;
    logic             r_emem_wr_en;
    logic [LBITS-1:0] r_emem_wr_addr;
    logic             r_llr_wr_en;
    logic [LBITS-1:0] r_llr_wr_addr;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [TBITS-1:0] w_timer_nxt;
    logic [LBITS-1:0] w_layer_nxt;
    logic [IBITS-1:0] w_iter_nxt;
    logic             w_all_ok_nxt;
    logic             w_conv_nxt;
    logic             w_rd_en_nxt;
    logic             w_emem_nxt;
    logic             w_llr_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_layer_nxt  = r_layer;
        w_iter_nxt   = r_iter;
        w_all_ok_nxt = r_all_ok;
        w_conv_nxt   = r_conv;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt  = ST_ISSUE;
                    w_layer_nxt  = '0;
                    w_iter_nxt   = '0;
                    w_all_ok_nxt = 1'b1;
                    w_conv_nxt   = 1'b0;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
                w_timer_nxt = TBITS'(1);
            end
            ST_WAIT: begin
                // Timer == PIPE_LAT is the LLR/D write-back cycle; the layer retires here.
                if (r_timer == T_PIPE) begin
                    w_timer_nxt  = '0;
                    w_all_ok_nxt = r_all_ok & bus.syn_ok;
                    if (r_layer == L_LAST) begin
                        w_state_nxt = ST_ITER_END;
                    end else begin
                        w_layer_nxt = r_layer + 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_ITER_END: begin
                w_iter_nxt = r_iter + 1'b1;
                if ((w_iter_nxt == I_MAX) || (EARLY_TERM && r_all_ok)) begin
                    w_state_nxt = ST_DONE;
                    w_conv_nxt  = EARLY_TERM && r_all_ok;
                end else begin
                    w_state_nxt  = ST_ISSUE;
                    w_layer_nxt  = '0;
                    w_all_ok_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they land registered in the right cycle.
        w_rd_en_nxt = (w_state_nxt == ST_ISSUE);
        w_emem_nxt  = (w_state_nxt == ST_WAIT) && (w_timer_nxt == T_EMSG);
        w_llr_nxt   = (w_state_nxt == ST_WAIT) && (w_timer_nxt == T_PIPE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_timer        <= '0;
            r_layer        <= '0;
            r_iter         <= '0;
            r_all_ok       <= 1'b0;
            r_conv         <= 1'b0;
            r_rd_en        <= 1'b0;
            r_rd_addr      <= '0;
            r_emem_wr_en   <= 1'b0;
            r_emem_wr_addr <= '0;
            r_llr_wr_en    <= 1'b0;
            r_llr_wr_addr  <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_timer        <= w_timer_nxt;
            r_layer        <= w_layer_nxt;
            r_iter         <= w_iter_nxt;
            r_all_ok       <= w_all_ok_nxt;
            r_conv         <= w_conv_nxt;
            r_rd_en        <= w_rd_en_nxt;
            r_rd_addr      <= w_rd_en_nxt ? w_layer_nxt : '0;
            r_emem_wr_en   <= w_emem_nxt;
            r_emem_wr_addr <= w_emem_nxt ? w_layer_nxt : '0;
            r_llr_wr_en    <= w_llr_nxt;
            r_llr_wr_addr  <= w_llr_nxt ? w_layer_nxt : '0;
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_done         <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.rd_en        = r_rd_en;
    assign bus.rd_addr      = r_rd_addr;
    assign bus.emem_wr_en   = r_emem_wr_en;
    assign bus.emem_wr_addr = r_emem_wr_addr;
    assign bus.llr_wr_en    = r_llr_wr_en;
    assign bus.llr_wr_addr  = r_llr_wr_addr;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.converged    = r_conv;
    assign bus.iter_cnt     = r_iter;

endmodule

// File: tb/tb_row_unit_sched.sv
// Self-checking bench for row_unit_sched: schedule table, reset, early-termination and random runs.
`timescale 1ns/1ps
module tb_row_unit_sched;

    localparam int LB    = 4;
    localparam int IB    = 4;
    localparam int EL    = 3;
    localparam int PL    = 10;
    localparam int PER   = PL + 1;
    localparam int NL_A  = 4;
    localparam int MI_A  = 2;
    localparam int IPER_A = NL_A * PER + 1;
    localparam int NL_B  = 6;
    localparam int MI_B  = 2;

`ifdef ROW_SCHED_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    row_unit_sched_if #(.LBITS(LB), .IBITS(IB)) bus_a ();
    row_unit_sched_if #(.LBITS(LB), .IBITS(IB)) bus_b ();

    row_unit_sched #(
        .NLAYERS(NL_A), .LBITS(LB), .MAXITER(MI_A), .IBITS(IB), .EMSG_LAT(EL), .PIPE_LAT(PL)
    ) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a)
    );

    row_unit_sched #(
        .NLAYERS(NL_B), .LBITS(LB), .MAXITER(MI_B), .IBITS(IB), .EMSG_LAT(EL), .PIPE_LAT(PL)
    ) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model for dut_a: position inside a codeword is pure arithmetic on the
    // cycle offset since start; only the iteration-exit decision needs memory.
    bit model_on = 1'b0;
    int m_ph   = 0;   // 0 idle, 1 decoding, 2 done cycle
    int m_t    = 0;
    int e_iter = 0;
    bit e_conv = 1'b0;
    bit m_ok   = 1'b1;
    int m_r, m_lay, m_pos;
    bit x_rd, x_em, x_llr, m_inl;

    always @(negedge clk) begin
        if (model_on) begin
            x_rd = 1'b0; x_em = 1'b0; x_llr = 1'b0; m_lay = 0; m_r = 0;
            if (m_ph == 1) begin
                m_r   = (m_t - 1) % IPER_A;
                m_inl = (m_r < NL_A * PER);
                m_lay = m_r / PER;
                m_pos = m_r % PER;
                x_rd  = m_inl && (m_pos == 0);
                x_em  = m_inl && (m_pos == EL);
                x_llr = m_inl && (m_pos == PL);
            end
            chk("m_rd_en",     int'(bus_a.rd_en),      int'(x_rd));
            chk("m_emem_wr",   int'(bus_a.emem_wr_en), int'(x_em));
            chk("m_llr_wr",    int'(bus_a.llr_wr_en),  int'(x_llr));
            if (x_rd)  chk("m_rd_addr",   int'(bus_a.rd_addr),      m_lay);
            if (x_em)  chk("m_emem_addr", int'(bus_a.emem_wr_addr), m_lay);
            if (x_llr) chk("m_llr_addr",  int'(bus_a.llr_wr_addr),  m_lay);
            chk("m_busy",      int'(bus_a.busy),      int'(m_ph != 0));
            chk("m_done",      int'(bus_a.done),      int'(m_ph == 2));
            chk("m_iter_cnt",  int'(bus_a.iter_cnt),  e_iter);
            chk("m_converged", int'(bus_a.converged), int'(e_conv));

            if (!rst_a) begin
                m_ph = 0; e_iter = 0; e_conv = 1'b0;
            end else begin
                case (m_ph)
                    0: if (bus_a.start) begin
                        m_ph = 1; m_t = 1; e_iter = 0; e_conv = 1'b0; m_ok = 1'b1;
                    end
                    1: begin
                        if (x_llr && !bus_a.syn_ok) m_ok = 1'b0;
                        if (m_r == IPER_A - 1) begin
                            e_iter++;
                            if ((e_iter == MI_A) || (ET && m_ok)) begin
                                m_ph   = 2;
                                e_conv = ET && m_ok;
                            end else begin
                                m_ok = 1'b1;
                            end
                        end
                        m_t++;
                    end
                    default: m_ph = 0;
                endcase
            end
        end
    end

    // Runs one codeword on dut_a; pat 0 = syn_ok always 1, pat 1 = syn_ok 0 on layer 2.
    task automatic run_cw(input int pat, output int done_t, output int it, output int cv);
        done_t = -1; it = -1; cv = -1;
        for (int t = 0; t < 300 && done_t < 0; t++) begin
            bus_a.start  = (t == 0);
            bus_a.syn_ok = (pat == 0) ? 1'b1 :
                           !((t >= 1) && (((t - 1) % IPER_A) == 2 * PER + PL));
            @(negedge clk);
            if (bus_a.done) begin
                done_t = t; it = int'(bus_a.iter_cnt); cv = int'(bus_a.converged);
            end
            @(posedge clk); #1;
        end
        bus_a.start  = 1'b0;
        bus_a.syn_ok = 1'b0;
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 200 && bus_a.busy; i++) begin
            @(posedge clk); #1;
        end
        chk("wait_idle_a", int'(bus_a.busy), 0);
    endtask

    typedef struct {
        int t; bit st; bit rd; bit em; bit llr; int la; bit busy; bit done; int iter;
    } vec_t;

    localparam int NV = 19;
    vec_t tab [NV];

    initial begin : main
        int k;
        bit hit;
        int d_t, d_it, d_cv;
        int strobes;
        logic [21:0] outs_b;

        tab[0]  = '{0,  1, 0, 0, 0, 0, 0, 0, 0};
        tab[1]  = '{1,  0, 1, 0, 0, 0, 1, 0, 0};
        tab[2]  = '{4,  0, 0, 1, 0, 0, 1, 0, 0};
        tab[3]  = '{11, 0, 0, 0, 1, 0, 1, 0, 0};
        tab[4]  = '{12, 0, 1, 0, 0, 1, 1, 0, 0};
        tab[5]  = '{15, 0, 0, 1, 0, 1, 1, 0, 0};
        tab[6]  = '{20, 1, 0, 0, 0, 0, 1, 0, 0};
        tab[7]  = '{22, 0, 0, 0, 1, 1, 1, 0, 0};
        tab[8]  = '{23, 0, 1, 0, 0, 2, 1, 0, 0};
        tab[9]  = '{34, 0, 1, 0, 0, 3, 1, 0, 0};
        tab[10] = '{44, 0, 0, 0, 1, 3, 1, 0, 0};
        tab[11] = '{45, 0, 0, 0, 0, 0, 1, 0, 0};
        tab[12] = '{46, 0, 1, 0, 0, 0, 1, 0, 1};
        tab[13] = '{57, 0, 1, 0, 0, 1, 1, 0, 1};
        tab[14] = '{89, 0, 0, 0, 1, 3, 1, 0, 1};
        tab[15] = '{90, 0, 0, 0, 0, 0, 1, 0, 1};
        tab[16] = '{91, 1, 0, 0, 0, 0, 1, 1, 2};
        tab[17] = '{92, 1, 0, 0, 0, 0, 0, 0, 2};
        tab[18] = '{93, 0, 1, 0, 0, 0, 1, 0, 0};

        bus_a.start = 1'b0; bus_a.syn_ok = 1'b0;
        bus_b.start = 1'b0; bus_b.syn_ok = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_on = 1'b1;
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        chk("reset_b_outs", int'({bus_b.rd_en, bus_b.emem_wr_en, bus_b.llr_wr_en,
                                   bus_b.busy, bus_b.done, bus_b.converged, bus_b.iter_cnt}), 0);
        @(posedge clk); #1;

        // Schedule table, with start pulses while busy, in DONE, and back-to-back.
        k = 0;
        for (int t = 0; t <= 93; t++) begin
            hit = (k < NV) && (tab[k].t == t);
            bus_a.start = hit && tab[k].st;
            @(negedge clk);
            if (hit) begin
                chk($sformatf("tab%0d_rd_en", t), int'(bus_a.rd_en),      int'(tab[k].rd));
                chk($sformatf("tab%0d_emem", t),  int'(bus_a.emem_wr_en), int'(tab[k].em));
                chk($sformatf("tab%0d_llr", t),   int'(bus_a.llr_wr_en),  int'(tab[k].llr));
                chk($sformatf("tab%0d_busy", t),  int'(bus_a.busy),       int'(tab[k].busy));
                chk($sformatf("tab%0d_done", t),  int'(bus_a.done),       int'(tab[k].done));
                chk($sformatf("tab%0d_iter", t),  int'(bus_a.iter_cnt),   tab[k].iter);
                chk($sformatf("tab%0d_conv", t),  int'(bus_a.converged),  0);
                if (tab[k].rd)  chk($sformatf("tab%0d_rd_addr", t),   int'(bus_a.rd_addr),      tab[k].la);
                if (tab[k].em)  chk($sformatf("tab%0d_emem_addr", t), int'(bus_a.emem_wr_addr), tab[k].la);
                if (tab[k].llr) chk($sformatf("tab%0d_llr_addr", t),  int'(bus_a.llr_wr_addr),  tab[k].la);
                k++;
            end
            @(posedge clk); #1;
        end
        bus_a.start = 1'b0;
        wait_idle_a();

        // All layers satisfied: early exit after one iteration only when the feature is built in.
        run_cw(0, d_t, d_it, d_cv);
        chk("et_all_ok_done_t", d_t,  ET ? IPER_A + 1 : MI_A * IPER_A + 1);
        chk("et_all_ok_iter",   d_it, ET ? 1 : MI_A);
        chk("et_all_ok_conv",   d_cv, ET ? 1 : 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("iter_held", int'(bus_a.iter_cnt), ET ? 1 : MI_A);

        // Layer 2 fails every iteration: full run, never converged.
        run_cw(1, d_t, d_it, d_cv);
        chk("l2_fail_done_t", d_t,  MI_A * IPER_A + 1);
        chk("l2_fail_iter",   d_it, MI_A);
        chk("l2_fail_conv",   d_cv, 0);

        // Random start/syn_ok/reset traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus_a.start  = ($urandom_range(0, 15) == 0);
            bus_a.syn_ok = ($urandom_range(0, 15) != 0);
            rst_a        = ($urandom_range(0, 299) != 0);
            @(posedge clk); #1;
        end
        bus_a.start = 1'b0;
        rst_a = 1'b1;

        // Reset held 3 cycles in the middle of layer 5's WAIT on dut_b.
        strobes = 0;
        for (int t = 0; t <= 110; t++) begin
            bus_b.start = (t == 0) || (t == 100);
            rst_b = !((t >= 60) && (t <= 62));
            @(negedge clk);
            outs_b = {bus_b.rd_en, bus_b.rd_addr, bus_b.emem_wr_en, bus_b.emem_wr_addr,
                      bus_b.llr_wr_en, bus_b.llr_wr_addr, bus_b.busy, bus_b.done,
                      bus_b.iter_cnt, bus_b.converged};
            if (t == 56) begin
                chk("b_rd_en_l5",   int'(bus_b.rd_en),   1);
                chk("b_rd_addr_l5", int'(bus_b.rd_addr), 5);
            end
            if (t == 59) begin
                chk("b_emem_l5",      int'(bus_b.emem_wr_en),   1);
                chk("b_emem_addr_l5", int'(bus_b.emem_wr_addr), 5);
            end
            if (t >= 61 && t <= 63) chk($sformatf("b_rst_outs_t%0d", t), int'(outs_b), 0);
            if (t >= 63 && t <= 100 &&
                (bus_b.rd_en || bus_b.emem_wr_en || bus_b.llr_wr_en || bus_b.busy || bus_b.done))
                strobes++;
            if (t == 101) begin
                chk("b_restart_rd_en",   int'(bus_b.rd_en),    1);
                chk("b_restart_rd_addr", int'(bus_b.rd_addr),  0);
                chk("b_restart_iter",    int'(bus_b.iter_cnt), 0);
            end
            @(posedge clk); #1;
        end
        chk("b_post_reset_strobes", strobes, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
